// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: decodes opcode/address/payload frames into memory-bus
// writes and prefetching reads; SCK/CSN/SDI are oversampled on the system clock.
`timescale 1ns/1ps

module spi_cmd_slave #(
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter logic [7:0]  CMD_WRITE    = 8'h02,
  parameter logic [7:0]  CMD_READ     = 8'h0B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk_i,
  input  logic        spi_cs_i,
  input  logic        spi_sdi0_i,
  output logic        spi_sdo0_o,
  output logic        spi_sdo_oe_o,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        rd_req_o,
  output logic [31:0] rd_addr_o,
  input  logic        rd_valid_i,
  input  logic [31:0] rd_data_i,
  output logic        busy_o,
  input  logic        err_clr_i,
  output logic [2:0]  err_o
);

  localparam int unsigned   DCW        = $clog2(DUMMY_CYCLES + 1);
  localparam logic [DCW-1:0] DUMMY_LAST = DCW'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_DUMMY,
    S_RDATA,
    S_IGNORE
  } state_e;

  logic [2:0]     sck_sync_q;
  logic [2:0]     cs_sync_q;
  logic [1:0]     sdi_sync_q;

  state_e         state_q, state_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0] dummy_cnt_q, dummy_cnt_d;
  logic [31:0]    shift_q, shift_d;
  logic [7:0]     opcode_q, opcode_d;
  logic [31:0]    addr_q, addr_d;
  logic           wr_valid_q, wr_valid_d;
  logic [31:0]    wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic           rd_req_q, rd_req_d;
  logic [31:0]    rd_addr_q, rd_addr_d;
  logic [31:0]    hold_q, hold_d;
  logic           have_q, have_d;
  logic [31:0]    sdo_shift_q, sdo_shift_d;
  logic           reload_q, reload_d;
  logic [2:0]     err_q, err_d;

  logic           sck_rise, sck_fall, cs_high, cs_fall, sdi_bit;
  logic [31:0]    shift_word;

  // CS synchroniser resets to deasserted so leaving reset never fakes a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync_q <= 3'b000;
      cs_sync_q  <= 3'b111;
      sdi_sync_q <= 2'b00;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], spi_clk_i};
      cs_sync_q  <= {cs_sync_q[1:0], spi_cs_i};
      sdi_sync_q <= {sdi_sync_q[0], spi_sdi0_i};
    end
  end

  assign sck_rise   = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall   = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_high    = cs_sync_q[1];
  assign cs_fall    = ~cs_sync_q[1] & cs_sync_q[2];
  assign sdi_bit    = sdi_sync_q[1];
  assign shift_word = {shift_q[30:0], sdi_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      dummy_cnt_q <= '0;
      shift_q     <= '0;
      opcode_q    <= '0;
      addr_q      <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      hold_q      <= '0;
      have_q      <= 1'b0;
      sdo_shift_q <= '0;
      reload_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      dummy_cnt_q <= dummy_cnt_d;
      shift_q     <= shift_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      hold_q      <= hold_d;
      have_q      <= have_d;
      sdo_shift_q <= sdo_shift_d;
      reload_q    <= reload_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    dummy_cnt_d = dummy_cnt_q;
    shift_d     = shift_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    hold_d      = hold_q;
    have_d      = have_q;
    sdo_shift_d = sdo_shift_q;
    reload_d    = reload_q;
    err_d       = err_q;

    // Clear first so any error raised below in the same cycle wins.
    if (err_clr_i) err_d = '0;
    if (wr_valid_q && wr_ready_i) wr_valid_d = 1'b0;

    if (cs_high && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      dummy_cnt_d = '0;
      have_d      = 1'b0;
      reload_d    = 1'b0;
      sdo_shift_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = '0;
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            shift_d   = shift_word;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              opcode_d  = shift_word[7:0];
              if (shift_word[7:0] == CMD_WRITE || shift_word[7:0] == CMD_READ) begin
                state_d = S_ADDR;
              end else begin
                state_d  = S_IGNORE;
                err_d[0] = 1'b1;
              end
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            shift_d   = shift_word;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_d = '0;
              addr_d    = shift_word;
              if (opcode_q == CMD_WRITE) begin
                state_d = S_WDATA;
              end else begin
                state_d     = S_DUMMY;
                rd_req_d    = 1'b1;
                rd_addr_d   = shift_word;
                dummy_cnt_d = '0;
                sdo_shift_d = '0;
              end
            end
          end
        end
        S_WDATA: begin
          if (sck_rise) begin
            shift_d   = shift_word;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              if (!wr_valid_q) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                wr_data_d  = shift_word;
              end else begin
                err_d[1] = 1'b1;
              end
              addr_d = addr_q + 32'd4;
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            dummy_cnt_d = dummy_cnt_q + DCW'(1);
            if (dummy_cnt_q == DUMMY_LAST) begin
              state_d   = S_RDATA;
              reload_d  = 1'b1;
              bit_cnt_d = '0;
            end
          end
        end
        S_RDATA: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) reload_d = 1'b1;
          end else if (sck_fall) begin
            if (reload_q) begin
              // Reload point: hand out the prefetched word and request the next one.
              reload_d = 1'b0;
              if (have_q) begin
                sdo_shift_d = hold_q;
                have_d      = 1'b0;
              end else begin
                sdo_shift_d = '0;
                err_d[2]    = 1'b1;
              end
              rd_req_d  = 1'b1;
              rd_addr_d = addr_q + 32'd4;
              addr_d    = addr_q + 32'd4;
            end else begin
              sdo_shift_d = {sdo_shift_q[30:0], 1'b0};
            end
          end
        end
        S_IGNORE: begin
        end
        default: state_d = S_IDLE;
      endcase

      // Captured last so data arriving on a reload cycle is kept for the next word.
      if ((state_q == S_DUMMY || state_q == S_RDATA) && rd_valid_i) begin
        hold_d = rd_data_i;
        have_d = 1'b1;
      end
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign spi_sdo_oe_o = (state_q == S_RDATA);
  assign spi_sdo0_o   = spi_sdo_oe_o & sdo_shift_q[31];
  assign wr_valid_o   = wr_valid_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign rd_req_o     = rd_req_q;
  assign rd_addr_o    = rd_addr_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: bit-banged SPI master, latency-4 memory model,
// and logs of bus writes and read requests.
`timescale 1ns/1ps

module tb_spi_cmd_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, cs, sdi;
  logic        sdo, sdoOe;
  logic        wrValid, wrReady;
  logic [31:0] wrAddr, wrData;
  logic        rdReq;
  logic [31:0] rdAddr;
  logic        rdValid = 1'b0;
  logic [31:0] rdData = '0;
  logic        busy, errClr;
  logic [2:0]  err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rxWord;
  logic        oeAll, oeAny;
  logic        memEnable = 1'b1;
  logic [3:0]  pipeV = '0;
  logic [31:0] pipeA [4];
  logic [31:0] wrAddrLog[$];
  logic [31:0] wrDataLog[$];
  logic [31:0] rdLog[$];

  spi_cmd_slave dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_clk_i    (sck),
    .spi_cs_i     (cs),
    .spi_sdi0_i   (sdi),
    .spi_sdo0_o   (sdo),
    .spi_sdo_oe_o (sdoOe),
    .wr_valid_o   (wrValid),
    .wr_ready_i   (wrReady),
    .wr_addr_o    (wrAddr),
    .wr_data_o    (wrData),
    .rd_req_o     (rdReq),
    .rd_addr_o    (rdAddr),
    .rd_valid_i   (rdValid),
    .rd_data_i    (rdData),
    .busy_o       (busy),
    .err_clr_i    (errClr),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Memory: word n above 0x2000 reads as 0xA5A5_0000 + n + 1, answered ~4 clk after the request.
  always @(negedge clk) begin
    rdValid = memEnable && pipeV[3];
    rdData  = pipeV[3] ? (32'hA5A5_0000 + ((pipeA[3] - 32'h2000) >> 2) + 32'd1) : 32'd0;
    for (int k = 3; k > 0; k--) begin
      pipeV[k] = pipeV[k-1];
      pipeA[k] = pipeA[k-1];
    end
    pipeV[0] = rdReq;
    pipeA[0] = rdAddr;
  end

  always @(negedge clk) begin
    #1;
    if (rst_n && wrValid && wrReady) begin
      wrAddrLog.push_back(wrAddr);
      wrDataLog.push_back(wrData);
    end
    if (rst_n && rdReq) rdLog.push_back(rdAddr);
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shifts nbits of val MSB first; MISO and OE are sampled at each SCK rise.
  task automatic applyStimulus(input logic [31:0] val, input int nbits);
    oeAll = 1'b1;
    for (int i = nbits - 1; i >= 0; i--) begin
      sck = 1'b0;
      sdi = val[i];
      waitClk(5);
      sck    = 1'b1;
      rxWord = {rxWord[30:0], sdo};
      oeAll  = oeAll & sdoOe;
      oeAny  = oeAny | sdoOe;
      waitClk(5);
    end
  endtask

  task automatic csLow();
    oeAny = 1'b0;
    cs    = 1'b0;
    waitClk(5);
  endtask

  // CS rises while SCK is still high so the trailing fall lands after deselect.
  task automatic csHigh();
    cs = 1'b1;
    waitClk(5);
    sck = 1'b0;
    waitClk(10);
  endtask

  task automatic clearLogs();
    wrAddrLog.delete();
    wrDataLog.delete();
    rdLog.delete();
  endtask

  initial begin
    rst_n   = 1'b0;
    cs      = 1'b1;
    sck     = 1'b0;
    sdi     = 1'b0;
    wrReady = 1'b1;
    errClr  = 1'b0;
    rxWord  = '0;
    oeAll   = 1'b1;
    oeAny   = 1'b0;
    waitClk(4);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_valid", 32'(wrValid), 32'd0);
    checkOutput("rst_rd_req", 32'(rdReq), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_oe", 32'(sdoOe), 32'd0);
    checkOutput("rst_sdo", 32'(sdo), 32'd0);
    checkOutput("rst_wr_addr", wrAddr, 32'd0);
    rst_n = 1'b1;
    waitClk(5);

    // Two-word write with ready tied high.
    clearLogs();
    csLow();
    applyStimulus(32'h02, 8);
    applyStimulus(32'h0000_1000, 32);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    applyStimulus(32'hDEAD_BEEF, 32);
    applyStimulus(32'h1234_5678, 32);
    csHigh();
    checkOutput("t1_wr_count", 32'(wrAddrLog.size()), 32'd2);
    if (wrAddrLog.size() == 2) begin
      checkOutput("t1_wr0_addr", wrAddrLog[0], 32'h0000_1000);
      checkOutput("t1_wr0_data", wrDataLog[0], 32'hDEAD_BEEF);
      checkOutput("t1_wr1_addr", wrAddrLog[1], 32'h0000_1004);
      checkOutput("t1_wr1_data", wrDataLog[1], 32'h1234_5678);
    end
    checkOutput("t1_err", 32'(err), 32'd0);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);

    // Two-word read with the memory model answering.
    clearLogs();
    csLow();
    applyStimulus(32'h0B, 8);
    applyStimulus(32'h0000_2000, 32);
    applyStimulus(32'h0, 32);
    checkOutput("t2_oe_before_data", 32'(oeAny), 32'd0);
    applyStimulus(32'h0, 32);
    checkOutput("t2_word0", rxWord, 32'hA5A5_0001);
    checkOutput("t2_oe_word0", 32'(oeAll), 32'd1);
    applyStimulus(32'h0, 32);
    checkOutput("t2_word1", rxWord, 32'hA5A5_0002);
    checkOutput("t2_oe_word1", 32'(oeAll), 32'd1);
    csHigh();
    checkOutput("t2_oe_end", 32'(sdoOe), 32'd0);
    checkOutput("t2_rdreq_count", 32'(rdLog.size()), 32'd3);
    if (rdLog.size() == 3) begin
      checkOutput("t2_rdreq0", rdLog[0], 32'h0000_2000);
      checkOutput("t2_rdreq1", rdLog[1], 32'h0000_2004);
      checkOutput("t2_rdreq2", rdLog[2], 32'h0000_2008);
    end
    checkOutput("t2_err", 32'(err), 32'd0);

    // Three-word write against a stalled bus.
    clearLogs();
    wrReady = 1'b0;
    csLow();
    applyStimulus(32'h02, 8);
    applyStimulus(32'h0000_3000, 32);
    applyStimulus(32'h1111_1111, 32);
    applyStimulus(32'h2222_2222, 32);
    applyStimulus(32'h3333_3333, 32);
    csHigh();
    checkOutput("t3_wr_valid_held", 32'(wrValid), 32'd1);
    checkOutput("t3_wr_addr_held", wrAddr, 32'h0000_3000);
    checkOutput("t3_wr_data_held", wrData, 32'h1111_1111);
    checkOutput("t3_err", 32'(err), 32'b010);
    checkOutput("t3_no_accept_yet", 32'(wrAddrLog.size()), 32'd0);
    wrReady = 1'b1;
    waitClk(5);
    checkOutput("t3_accept_count", 32'(wrAddrLog.size()), 32'd1);
    checkOutput("t3_wr_valid_drop", 32'(wrValid), 32'd0);
    errClr = 1'b1;
    waitClk(1);
    errClr = 1'b0;
    waitClk(1);
    checkOutput("t3_err_cleared", 32'(err), 32'd0);

    // Read with no memory response.
    clearLogs();
    memEnable = 1'b0;
    csLow();
    applyStimulus(32'h0B, 8);
    applyStimulus(32'h0000_4000, 32);
    applyStimulus(32'h0, 32);
    applyStimulus(32'h0, 32);
    checkOutput("t4_word_zero", rxWord, 32'h0);
    csHigh();
    checkOutput("t4_err", 32'(err), 32'b100);
    errClr = 1'b1;
    waitClk(1);
    errClr = 1'b0;
    waitClk(1);
    checkOutput("t4_err_cleared", 32'(err), 32'd0);
    memEnable = 1'b1;
    waitClk(10);

    // Unknown opcode followed by a valid write.
    clearLogs();
    csLow();
    applyStimulus(32'h55, 8);
    applyStimulus(32'hFFFF_FFFF, 32);
    applyStimulus(32'hFF, 8);
    csHigh();
    checkOutput("t5_oe_never", 32'(oeAny), 32'd0);
    checkOutput("t5_err", 32'(err), 32'b001);
    checkOutput("t5_no_writes", 32'(wrAddrLog.size()), 32'd0);
    checkOutput("t5_no_reads", 32'(rdLog.size()), 32'd0);
    csLow();
    applyStimulus(32'h02, 8);
    applyStimulus(32'h0000_5000, 32);
    applyStimulus(32'hCAFE_F00D, 32);
    csHigh();
    checkOutput("t5_wr_count", 32'(wrAddrLog.size()), 32'd1);
    if (wrAddrLog.size() == 1) begin
      checkOutput("t5_wr_addr", wrAddrLog[0], 32'h0000_5000);
      checkOutput("t5_wr_data", wrDataLog[0], 32'hCAFE_F00D);
    end
    checkOutput("t5_err_sticky", 32'(err), 32'b001);

    // Aborted write, then reset in the middle of a read.
    clearLogs();
    csLow();
    applyStimulus(32'h02, 8);
    applyStimulus(32'h0000_6000, 32);
    applyStimulus(32'h000A_BCDE, 20);
    csHigh();
    checkOutput("t6_abort_no_write", 32'(wrAddrLog.size()), 32'd0);
    checkOutput("t6_abort_idle", 32'(busy), 32'd0);
    csLow();
    applyStimulus(32'h0B, 8);
    applyStimulus(32'h0000_2000, 32);
    applyStimulus(32'h0, 10);
    checkOutput("t6_busy_mid_read", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cs    = 1'b1;
    sck   = 1'b0;
    waitClk(1);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_err", 32'(err), 32'd0);
    checkOutput("t6_rst_rd_addr", rdAddr, 32'd0);
    checkOutput("t6_rst_wr_addr", wrAddr, 32'd0);
    checkOutput("t6_rst_wr_data", wrData, 32'd0);
    checkOutput("t6_rst_oe", 32'(sdoOe), 32'd0);
    waitClk(3);
    rst_n = 1'b1;
    waitClk(5);
    clearLogs();
    csLow();
    applyStimulus(32'h02, 8);
    applyStimulus(32'h0000_7000, 32);
    applyStimulus(32'h0BAD_C0DE, 32);
    csHigh();
    checkOutput("t6_post_wr_count", 32'(wrAddrLog.size()), 32'd1);
    if (wrAddrLog.size() == 1) begin
      checkOutput("t6_post_wr_addr", wrAddrLog[0], 32'h0000_7000);
      checkOutput("t6_post_wr_data", wrDataLog[0], 32'h0BAD_C0DE);
    end
    checkOutput("t6_post_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
